// File: rtl/instr_decode_stage_pkg.sv
// ---------------------------------------------------------------------------
// instr_decode_stage_pkg
// Shared decode constants for the instruction decode stage: the opcodes that
// select the instruction format, the opcodes whose immediate is
// zero-extended, the format enumeration and the skid-buffer state encoding.
// ---------------------------------------------------------------------------
package instr_decode_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  // The zero-extend list is a flat vector of ZEXT_N six-bit opcodes.
  localparam int ZEXT_N = 3;
  localparam logic [6*ZEXT_N-1:0] ZEXT_OPS_DEFAULT = {OP_ANDI, OP_ORI, OP_XORI};

  // Instruction format reported downstream; the encoding 3 is never produced.
  typedef enum logic [1:0] {
    FMT_R = 2'd0,
    FMT_I = 2'd1,
    FMT_J = 2'd2
  } fmt_e;

  // Occupancy of the two-entry skid buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // True when the opcode appears anywhere in the zero-extend list.
  function automatic logic isZextOp(input logic [5:0] op,
                                    input logic [6*ZEXT_N-1:0] list);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < ZEXT_N; k++) begin
      if (list[6*k +: 6] == op) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/instr_decode_stage_if.sv
// ---------------------------------------------------------------------------
// instr_decode_stage_if
// Handshake bundle of the decode stage.
//   in_valid/in_ready/in_instr/in_pc : upstream raw instruction channel
//   out_valid/out_ready/out_*        : downstream decoded-field channel
// Modports:
//   master : the environment (drives in_*, out_ready; observes the rest)
//   slave  : the decode stage itself
// ---------------------------------------------------------------------------
interface instr_decode_stage_if #(
  parameter int PC_W  = 32,
  parameter int IMM_W = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [PC_W-1:0]  in_pc;

  logic             out_valid;
  logic             out_ready;
  logic [5:0]       out_opcode;
  logic [5:0]       out_funct;
  logic [4:0]       out_rs;
  logic [4:0]       out_rt;
  logic [4:0]       out_rd;
  logic [4:0]       out_shamt;
  logic [IMM_W-1:0] out_imm;
  logic [25:0]      out_jtarget;
  logic [1:0]       out_fmt;
  logic [PC_W-1:0]  out_pc;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_opcode, out_funct, out_rs, out_rt,
           out_rd, out_shamt, out_imm, out_jtarget, out_fmt, out_pc
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_opcode, out_funct, out_rs, out_rt,
           out_rd, out_shamt, out_imm, out_jtarget, out_fmt, out_pc
  );

endinterface

// File: rtl/instr_decode_stage_field_decode.sv
// ---------------------------------------------------------------------------
// instr_field_decode
// Purely combinational field extraction for a MIPS-style instruction word.
//   instr_i    : raw 32-bit instruction
//   opcode_o   : bits [31:26]        funct_o  : bits [5:0]
//   rs_o/rt_o  : bits [25:21]/[20:16] rd_o    : bits [15:11]
//   shamt_o    : bits [10:6]          jtarget_o: bits [25:0]
//   imm_o      : bits [15:0] zero-extended for ZEXT_OPS, else sign-extended
//   fmt_o      : R for opcode 0, J for j/jal, I for everything else
// ---------------------------------------------------------------------------
module instr_field_decode
  import instr_decode_stage_pkg::*;
#(
  parameter int                    IMM_W    = 32,
  parameter logic [6*ZEXT_N-1:0]   ZEXT_OPS = ZEXT_OPS_DEFAULT
) (
  input  logic [31:0]      instr_i,
  output logic [5:0]       opcode_o,
  output logic [5:0]       funct_o,
  output logic [4:0]       rs_o,
  output logic [4:0]       rt_o,
  output logic [4:0]       rd_o,
  output logic [4:0]       shamt_o,
  output logic [IMM_W-1:0] imm_o,
  output logic [25:0]      jtarget_o,
  output fmt_e             fmt_o
);

  logic [15:0] imm16;

  assign opcode_o  = instr_i[31:26];
  assign rs_o      = instr_i[25:21];
  assign rt_o      = instr_i[20:16];
  assign rd_o      = instr_i[15:11];
  assign shamt_o   = instr_i[10:6];
  assign funct_o   = instr_i[5:0];
  assign jtarget_o = instr_i[25:0];
  assign imm16     = instr_i[15:0];

  // Size casts keep this correct even when IMM_W is exactly 16, where a
  // zero-count replication would otherwise be needed.
  assign imm_o = isZextOp(instr_i[31:26], ZEXT_OPS) ? IMM_W'(imm16)
                                                    : IMM_W'($signed(imm16));

  // Format classification from the opcode alone.
  always_comb begin
    fmt_o = FMT_I;
    case (instr_i[31:26])
      OP_RTYPE:      fmt_o = FMT_R;
      OP_J, OP_JAL:  fmt_o = FMT_J;
      default:       fmt_o = FMT_I;
    endcase
  end

endmodule

// File: rtl/instr_decode_stage.sv
// ---------------------------------------------------------------------------
// instr_decode_stage
// Decodes MIPS-style instruction words as they are accepted and stores the
// decoded fields in a two-entry skid buffer, so the stage sustains one
// instruction per cycle with one cycle of latency while keeping in_ready a
// pure register output.
//   clk    : single clock, rising edge
//   rst_n  : synchronous active-low reset (empties the buffer, zeroes data)
//   flush  : empties the buffer on the next edge, dropping any offered input
//   bus    : slave side of instr_decode_stage_if (in_* / out_* channels)
// ---------------------------------------------------------------------------
module instr_decode_stage
  import instr_decode_stage_pkg::*;
#(
  parameter int                  PC_W     = 32,
  parameter int                  IMM_W    = 32,
  parameter logic [6*ZEXT_N-1:0] ZEXT_OPS = ZEXT_OPS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  instr_decode_stage_if.slave  bus
);

  // One pre-decoded buffer entry.
  typedef struct packed {
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [4:0]       shamt;
    logic [IMM_W-1:0] imm;
    logic [25:0]      jtarget;
    fmt_e             fmt;
    logic [PC_W-1:0]  pc;
  } entry_t;

  state_e state_q, state_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;
  logic   inReady_q;
  entry_t inEntry;
  logic   inTx;
  logic   outTx;

  // Decode happens on the input side so every stored entry is already
  // split into fields; the output is then a plain register read.
  instr_field_decode #(
    .IMM_W    (IMM_W),
    .ZEXT_OPS (ZEXT_OPS)
  ) u_field_decode (
    .instr_i   (bus.in_instr),
    .opcode_o  (inEntry.opcode),
    .funct_o   (inEntry.funct),
    .rs_o      (inEntry.rs),
    .rt_o      (inEntry.rt),
    .rd_o      (inEntry.rd),
    .shamt_o   (inEntry.shamt),
    .imm_o     (inEntry.imm),
    .jtarget_o (inEntry.jtarget),
    .fmt_o     (inEntry.fmt)
  );

  assign inEntry.pc = bus.in_pc;

  assign inTx  = bus.in_valid && inReady_q;
  assign outTx = (state_q != ST_EMPTY) && bus.out_ready;

  // Next-state and data movement. The head slot always holds the oldest
  // entry; the tail slot only fills when the head is stalled, and it slides
  // into the head when the head drains. Flush overrides every transition.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      ST_EMPTY: begin
        if (inTx) begin
          state_d = ST_ONE;
          head_d  = inEntry;
        end
      end
      ST_ONE: begin
        if (inTx && outTx) begin
          head_d = inEntry;
        end else if (inTx) begin
          state_d = ST_FULL;
          tail_d  = inEntry;
        end else if (outTx) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (outTx) begin
          state_d = ST_ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
  end

  // State register. in_ready is registered from the next state so it never
  // has a combinational path from out_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      head_q    <= '0;
      tail_q    <= '0;
      inReady_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      inReady_q <= (state_d != ST_FULL);
    end
  end

  assign bus.in_ready    = inReady_q;
  assign bus.out_valid   = (state_q != ST_EMPTY);
  assign bus.out_opcode  = head_q.opcode;
  assign bus.out_funct   = head_q.funct;
  assign bus.out_rs      = head_q.rs;
  assign bus.out_rt      = head_q.rt;
  assign bus.out_rd      = head_q.rd;
  assign bus.out_shamt   = head_q.shamt;
  assign bus.out_imm     = head_q.imm;
  assign bus.out_jtarget = head_q.jtarget;
  assign bus.out_fmt     = head_q.fmt;
  assign bus.out_pc      = head_q.pc;

endmodule

// File: tb/tb_instr_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_instr_decode_stage
// Directed and randomised self-checking bench for instr_decode_stage.
// Inputs change on the falling edge; outputs are sampled on the falling
// edge, half a cycle away from the capturing rising edge.
// ---------------------------------------------------------------------------
module tb_instr_decode_stage;

  localparam int PC_W  = 32;
  localparam int IMM_W = 32;
  localparam int FW    = 6 + 6 + 5*4 + IMM_W + 26 + 2 + PC_W;

  logic clk;
  logic rst_n;
  logic flush;

  int testsRun;
  int testsFailed;

  instr_decode_stage_if #(.PC_W(PC_W), .IMM_W(IMM_W)) ifc ();

  instr_decode_stage #(
    .PC_W  (PC_W),
    .IMM_W (IMM_W)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (ifc)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference decode of one instruction plus its PC, packed in
  // the same field order as actualFields().
  function automatic logic [FW-1:0] expFields(input logic [31:0] ins,
                                              input logic [PC_W-1:0] pc);
    logic [5:0]       op;
    logic [1:0]       fmt;
    logic [IMM_W-1:0] imm;
    op = ins[31:26];
    if (op == 6'h00) fmt = 2'd0;
    else if (op == 6'h02 || op == 6'h03) fmt = 2'd2;
    else fmt = 2'd1;
    if (op == 6'h0C || op == 6'h0D || op == 6'h0E) imm = {16'h0000, ins[15:0]};
    else imm = {{16{ins[15]}}, ins[15:0]};
    return {op, ins[5:0], ins[25:21], ins[20:16], ins[15:11], ins[10:6],
            imm, ins[25:0], fmt, pc};
  endfunction

  function automatic logic [FW-1:0] actualFields();
    return {ifc.out_opcode, ifc.out_funct, ifc.out_rs, ifc.out_rt, ifc.out_rd,
            ifc.out_shamt, ifc.out_imm, ifc.out_jtarget, ifc.out_fmt, ifc.out_pc};
  endfunction

  // Reset state: empty, ready, all data fields zero.
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    flush = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_instr = 32'hDEADBEEF;
    ifc.in_pc = 32'h0;
    ifc.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    testsRun++;
    if (ifc.out_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_out_valid got %b want 0", ifc.out_valid);
    end
    testsRun++;
    if (ifc.in_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_in_ready got %b want 1", ifc.in_ready);
    end
    testsRun++;
    if (actualFields() !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_fields got %h want 0", actualFields());
    end
  endtask

  // add $8,$9,$10 decodes as an R-type with the expected register fields.
  task automatic test_rtype();
    ifc.out_ready = 1'b1;
    ifc.in_valid = 1'b1;
    ifc.in_instr = 32'h012A4020;
    ifc.in_pc = 32'h0000_0100;
    @(negedge clk);
    ifc.in_valid = 1'b0;
    testsRun++;
    if (ifc.out_valid !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL rtype_valid got %b want 1", ifc.out_valid);
    end
    testsRun++;
    if (ifc.out_fmt !== 2'd0) begin
      testsFailed++;
      $display("[TB] FAIL rtype_fmt got %0d want 0", ifc.out_fmt);
    end
    testsRun++;
    if ({ifc.out_rs, ifc.out_rt, ifc.out_rd} !== {5'd9, 5'd10, 5'd8}) begin
      testsFailed++;
      $display("[TB] FAIL rtype_regs got rs=%0d rt=%0d rd=%0d want 9 10 8",
               ifc.out_rs, ifc.out_rt, ifc.out_rd);
    end
    testsRun++;
    if (ifc.out_funct !== 6'h20) begin
      testsFailed++;
      $display("[TB] FAIL rtype_funct got %h want 20", ifc.out_funct);
    end
    testsRun++;
    if (ifc.out_pc !== 32'h0000_0100) begin
      testsFailed++;
      $display("[TB] FAIL rtype_pc got %h want 00000100", ifc.out_pc);
    end
    @(negedge clk);
  endtask

  // addi sign-extends, ori zero-extends; offered back to back.
  task automatic test_imm();
    ifc.out_ready = 1'b1;
    ifc.in_valid = 1'b1;
    ifc.in_instr = 32'h2128FFFF;
    ifc.in_pc = 32'h0000_0200;
    @(negedge clk);
    ifc.in_instr = 32'h3528FFFF;
    ifc.in_pc = 32'h0000_0204;
    testsRun++;
    if (ifc.out_imm !== 32'hFFFFFFFF || ifc.out_fmt !== 2'd1) begin
      testsFailed++;
      $display("[TB] FAIL addi_imm got imm=%h fmt=%0d want FFFFFFFF 1",
               ifc.out_imm, ifc.out_fmt);
    end
    @(negedge clk);
    ifc.in_valid = 1'b0;
    testsRun++;
    if (ifc.out_imm !== 32'h0000FFFF || ifc.out_pc !== 32'h0000_0204) begin
      testsFailed++;
      $display("[TB] FAIL ori_imm got imm=%h pc=%h want 0000FFFF 00000204",
               ifc.out_imm, ifc.out_pc);
    end
    @(negedge clk);
  endtask

  // jal is J-format with the 26-bit target.
  task automatic test_jal();
    ifc.out_ready = 1'b1;
    ifc.in_valid = 1'b1;
    ifc.in_instr = 32'h0C100004;
    ifc.in_pc = 32'h0000_0300;
    @(negedge clk);
    ifc.in_valid = 1'b0;
    testsRun++;
    if (ifc.out_fmt !== 2'd2) begin
      testsFailed++;
      $display("[TB] FAIL jal_fmt got %0d want 2", ifc.out_fmt);
    end
    testsRun++;
    if (ifc.out_jtarget !== 26'h0100004) begin
      testsFailed++;
      $display("[TB] FAIL jal_target got %h want 0100004", ifc.out_jtarget);
    end
    @(negedge clk);
    testsRun++;
    if (ifc.out_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL jal_drain got valid=%b want 0", ifc.out_valid);
    end
  endtask

  // Three instructions against a stalled output: two fit, then in_ready
  // drops; on release all three come out in order exactly once.
  task automatic test_backpressure();
    logic [31:0]     list [3];
    logic [FW-1:0]   expQ [$];
    logic [FW-1:0]   held;
    logic            holding;
    int              sent;
    int              got;
    list[0] = 32'h012A4020;
    list[1] = 32'h3528FFFF;
    list[2] = 32'h0C100004;
    sent = 0;
    got = 0;
    holding = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      ifc.out_ready = (cyc >= 5);
      ifc.in_valid = (sent < 3);
      ifc.in_instr = list[sent % 3];
      ifc.in_pc = 32'h0000_1000 + 32'(sent * 4);
      if (holding) begin
        testsRun++;
        if (actualFields() !== held) begin
          testsFailed++;
          $display("[TB] FAIL bp_stable got %h want %h", actualFields(), held);
        end
      end
      if (cyc == 3) begin
        testsRun++;
        if (ifc.in_ready !== 1'b0 || sent != 2) begin
          testsFailed++;
          $display("[TB] FAIL bp_full got in_ready=%b accepted=%0d want 0 2",
                   ifc.in_ready, sent);
        end
      end
      holding = ifc.out_valid && !ifc.out_ready;
      held = actualFields();
      if (ifc.out_valid && ifc.out_ready) begin
        testsRun++;
        if (expQ.size() == 0) begin
          testsFailed++;
          $display("[TB] FAIL bp_extra got %h want nothing", actualFields());
        end else begin
          logic [FW-1:0] want;
          want = expQ.pop_front();
          if (actualFields() !== want) begin
            testsFailed++;
            $display("[TB] FAIL bp_order got %h want %h", actualFields(), want);
          end
        end
        got++;
      end
      if (ifc.in_valid && ifc.in_ready) begin
        expQ.push_back(expFields(ifc.in_instr, ifc.in_pc));
        sent++;
      end
      @(negedge clk);
    end
    ifc.in_valid = 1'b0;
    testsRun++;
    if (got != 3 || expQ.size() != 0 || ifc.out_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL bp_count got %0d outputs valid=%b want 3 0",
               got, ifc.out_valid);
    end
  endtask

  // Flush from ONE (offered input accepted-but-dropped) and from FULL.
  task automatic test_flush();
    logic sawValid;
    ifc.out_ready = 1'b0;
    ifc.in_valid = 1'b1;
    ifc.in_instr = 32'h2128FFFF;
    ifc.in_pc = 32'h0000_2000;
    @(negedge clk);
    ifc.in_instr = 32'h3528FFFF;
    ifc.in_pc = 32'h0000_2004;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    ifc.in_valid = 1'b0;
    testsRun++;
    if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL flush_one got valid=%b ready=%b want 0 1",
               ifc.out_valid, ifc.in_ready);
    end
    ifc.in_valid = 1'b1;
    ifc.in_instr = 32'h012A4020;
    ifc.in_pc = 32'h0000_2100;
    @(negedge clk);
    ifc.in_pc = 32'h0000_2104;
    @(negedge clk);
    testsRun++;
    if (ifc.in_ready !== 1'b0 || ifc.out_valid !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL flush_prefill got ready=%b valid=%b want 0 1",
               ifc.in_ready, ifc.out_valid);
    end
    ifc.in_instr = 32'h0C100004;
    ifc.in_pc = 32'h0000_2108;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    ifc.in_valid = 1'b0;
    testsRun++;
    if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL flush_full got valid=%b ready=%b want 0 1",
               ifc.out_valid, ifc.in_ready);
    end
    ifc.out_ready = 1'b1;
    sawValid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ifc.out_valid) sawValid = 1'b1;
    end
    testsRun++;
    if (sawValid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL flush_ghost got valid output after flush want none");
    end
  endtask

  // Reset with an entry buffered and a transfer and flush both offered.
  task automatic test_reset_mid();
    ifc.out_ready = 1'b0;
    ifc.in_valid = 1'b1;
    ifc.in_instr = 32'h2128FFFF;
    ifc.in_pc = 32'h0000_3000;
    @(negedge clk);
    ifc.in_pc = 32'h0000_3004;
    ifc.out_ready = 1'b1;
    flush = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    flush = 1'b0;
    ifc.in_valid = 1'b0;
    testsRun++;
    if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1 || actualFields() !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid got valid=%b ready=%b fields=%h want 0 1 0",
               ifc.out_valid, ifc.in_ready, actualFields());
    end
  endtask

  // Random valid/ready for 10k instructions against a scoreboard.
  task automatic test_random();
    logic [FW-1:0] expQ [$];
    logic [FW-1:0] held;
    logic          holding;
    logic [31:0]   curInstr;
    int            sent;
    int            got;
    int            cyc;
    sent = 0;
    got = 0;
    cyc = 0;
    holding = 1'b0;
    held = '0;
    curInstr = $urandom;
    while (got < 10000 && cyc < 60000) begin
      ifc.in_valid = (sent < 10000) && ($urandom_range(0, 9) < 7);
      ifc.in_instr = curInstr;
      ifc.in_pc = 32'(sent * 4);
      ifc.out_ready = ($urandom_range(0, 1) == 1);
      if (holding) begin
        testsRun++;
        if (actualFields() !== held) begin
          testsFailed++;
          $display("[TB] FAIL rnd_stable got %h want %h", actualFields(), held);
        end
      end
      holding = ifc.out_valid && !ifc.out_ready;
      held = actualFields();
      if (ifc.out_valid && ifc.out_ready) begin
        testsRun++;
        if (expQ.size() == 0) begin
          testsFailed++;
          $display("[TB] FAIL rnd_extra got %h want nothing", actualFields());
        end else begin
          logic [FW-1:0] want;
          want = expQ.pop_front();
          if (actualFields() !== want) begin
            testsFailed++;
            $display("[TB] FAIL rnd_order got %h want %h", actualFields(), want);
          end
        end
        got++;
      end
      if (ifc.in_valid && ifc.in_ready) begin
        expQ.push_back(expFields(ifc.in_instr, ifc.in_pc));
        sent++;
        curInstr = $urandom;
      end
      @(negedge clk);
      cyc++;
    end
    ifc.in_valid = 1'b0;
    testsRun++;
    if (got != 10000 || expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL rnd_count got %0d outputs, %0d pending want 10000 0",
               got, expQ.size());
    end
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_instr = 32'h0;
    ifc.in_pc = 32'h0;
    ifc.out_ready = 1'b0;
    test_reset();
    test_rtype();
    test_imm();
    test_jal();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
